// File: rtl/apb_pkg.sv
// Shared definitions for the 9-bit address / 8-bit data APB peripheral bus.
// Used by the master bridge and by every completer on the bus.
package apb_pkg;

    localparam int unsigned APB_ADDR_W  = 9;
    localparam int unsigned APB_DATA_W  = 8;
    localparam int unsigned APB_SEL_BIT = 8;
    localparam int unsigned APB_IDX_W   = APB_SEL_BIT;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERRSTROBE} apb_slv_state_t;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x 8 register array behind the APB completer.
// One synchronous write port and one combinational read port; async reset to RESET_DATA.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned           DEPTH      = 64,
    parameter int unsigned           IDX_W      = 6,
    parameter logic [APB_DATA_W-1:0] RESET_DATA = 8'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      widx_i,
    input  logic [APB_DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]      ridx_i,
    output logic [APB_DATA_W-1:0] rdata_o
);

    logic [APB_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_DATA;
            end
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    // Guard covers non-power-of-two depths where the index can exceed the array.
    assign rdata_o = (32'(ridx_i) < DEPTH) ? mem_q[ridx_i] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer fronting a small register memory, with parameterised wait states
// and PSLVERR on protocol violations or out-of-range addresses.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned           DEPTH       = 64,
    parameter int unsigned           WAIT_STATES = 1,
    parameter logic [APB_DATA_W-1:0] RESET_DATA  = 8'h00
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned     IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_STATES);

    apb_slv_state_t        state_q;
    logic [CntW-1:0]       cnt_q;
    logic [APB_IDX_W-1:0]  addr_q;
    logic                  wr_q, err_q;
    logic [APB_DATA_W-1:0] wdata_q, rdreg_q, prdata_q;
    logic                  pready_q, pslverr_q;

    logic [APB_IDX_W-1:0]  idx_in;
    logic [APB_DATA_W-1:0] mem_rdata, rd_capture;
    logic                  mismatch, oor, setup_err, access_err;
    logic                  setup_req, latch_en, mem_we, unused_sel;

    assign idx_in     = PADDR[APB_IDX_W-1:0];
    assign unused_sel = PADDR[APB_SEL_BIT];

    assign mismatch   = (idx_in != addr_q) || (PWRITE != wr_q) || (wr_q && (PWDATA != wdata_q));
    assign oor        = (32'(addr_q) >= DEPTH);
    assign setup_err  = mismatch || oor;
    assign access_err = err_q || mismatch || !PENABLE || oor;

    assign setup_req  = PSEL && !PENABLE;
    assign latch_en   = setup_req && ((state_q == IDLE) || (state_q == SETUP) ||
                                      ((state_q == ACCESS) && pready_q));

    // The completion edge is the one ending the PREADY cycle.
    assign mem_we     = (state_q == ACCESS) && pready_q && wr_q && !pslverr_q;

    // Forward a write completing on the same edge a back-to-back read samples the array.
    assign rd_capture = (mem_we && (idx_in == addr_q)) ? wdata_q : mem_rdata;

    apb_slave_regfile #(
        .DEPTH      (DEPTH),
        .IDX_W      (IdxW),
        .RESET_DATA (RESET_DATA)
    ) u_regfile (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .we_i    (mem_we),
        .widx_i  (addr_q[IdxW-1:0]),
        .wdata_i (wdata_q),
        .ridx_i  (idx_in[IdxW-1:0]),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdreg_q <= '0;
        end else if (latch_en) begin
            addr_q  <= idx_in;
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            rdreg_q <= rd_capture;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (setup_req) begin
                        state_q <= SETUP;
                        cnt_q   <= CntLoad;
                        err_q   <= 1'b0;
                    end else if (PSEL && PENABLE) begin
                        state_q   <= ERRSTROBE;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else if (!PENABLE) begin
                        cnt_q <= CntLoad;
                        err_q <= 1'b0;
                    end else begin
                        state_q <= ACCESS;
                        err_q   <= setup_err;
                        if (cnt_q == '0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= setup_err;
                            prdata_q  <= (wr_q || setup_err) ? '0 : rdreg_q;
                        end
                    end
                end
                ACCESS: begin
                    if (pready_q) begin
                        if (setup_req) begin
                            state_q <= SETUP;
                            cnt_q   <= CntLoad;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (!PSEL) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        err_q <= access_err;
                        if (cnt_q == CntW'(1)) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= access_err;
                            prdata_q  <= (wr_q || access_err) ? '0 : rdreg_q;
                        end
                    end
                end
                ERRSTROBE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule
